// File: rtl/fsk_iq_modulator_if.sv
// AXI4-Stream channel bundle shared by the FSK modulator's bit input and I/Q outputs.
interface fsk_iq_modulator_if #(
   parameter int unsigned DATA_W = 16
);
   logic [DATA_W-1:0]   tdata;
   logic [DATA_W/8-1:0] tkeep;
   logic                tvalid;
   logic                tready;
   logic                tlast;

   modport master (output tdata, tkeep, tvalid, tlast, input tready);
   modport slave  (input tdata, tkeep, tvalid, tlast, output tready);
endinterface

// File: rtl/fsk_iq_modulator.sv
// Continuous-phase FSK modulator: one input bit -> SPS lock-stepped I (sin) / Q (cos) samples.
// Optional macro FSK_PHASE_RESET_EN: phase restarts at 0 for every packet.
module fsk_iq_modulator #(
   parameter int unsigned SPS        = 8,
   parameter int unsigned PHASE_W    = 32,
   parameter int unsigned LUT_AW     = 8,
   parameter logic [31:0] FREQ_INC_0 = 32'h0200_0000,
   parameter logic [31:0] FREQ_INC_1 = 32'h0400_0000,
   parameter int unsigned AMPLITUDE  = 32767
) (
   input  logic               clock,
   input  logic               reset,
   fsk_iq_modulator_if.slave  s_axis_bit,
   fsk_iq_modulator_if.master m_axis_i,
   fsk_iq_modulator_if.master m_axis_q
);
   localparam int unsigned LUT_DEPTH = 1 << LUT_AW;
   localparam int unsigned CNT_W     = (SPS > 1) ? $clog2(SPS) : 1;

   typedef enum logic {S_IDLE, S_SYM} state_t;

   function automatic logic signed [15:0] sine_entry(input int unsigned k);
      real v;
      v = real'(AMPLITUDE) * $sin(6.283185307179586 * real'(k) / real'(LUT_DEPTH));
      if (v >= 0.0) return 16'($rtoi(v + 0.5));
      return -16'($rtoi(0.5 - v));
   endfunction

   logic signed [15:0] w_rom [LUT_DEPTH];
   for (genvar g = 0; g < int'(LUT_DEPTH); g++) begin : g_rom
      localparam logic signed [15:0] ENTRY = sine_entry(g);
      assign w_rom[g] = ENTRY;
   end

   state_t              r_state, w_state_nx;
   logic                r_bit, r_bit_last;
   logic [CNT_W-1:0]    r_cnt;
   logic [PHASE_W-1:0]  r_phase, w_phase_nx, w_inc;
   logic                r_s1_valid, r_s1_last;
   logic signed [15:0]  r_lut_i, r_lut_q;
   logic                r_out_valid, r_out_last;
   logic signed [15:0]  r_out_i, r_out_q;
   logic                w_adv, w_tready, w_issue, w_accept, w_sym_end, w_s0_last;
   logic [LUT_AW-1:0]   w_idx_i, w_idx_q;
   logic                w_unused;

   assign w_adv     = !r_out_valid || (m_axis_i.tready && m_axis_q.tready);
   assign w_sym_end = (r_cnt == CNT_W'(SPS - 1));
   assign w_s0_last = r_bit_last && w_sym_end;
   assign w_accept  = s_axis_bit.tvalid && w_tready;
   assign w_inc     = r_bit ? PHASE_W'(FREQ_INC_1) : PHASE_W'(FREQ_INC_0);
   assign w_idx_i   = r_phase[PHASE_W-1 -: LUT_AW];
   assign w_idx_q   = w_idx_i + LUT_AW'(LUT_DEPTH / 4);
   assign w_unused  = ^{s_axis_bit.tdata[7:1], s_axis_bit.tkeep};

   always_comb begin
      w_state_nx = r_state;
      w_tready   = 1'b0;
      w_issue    = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_tready = w_adv;
            if (s_axis_bit.tvalid && w_adv) w_state_nx = S_SYM;
         end
         S_SYM: begin
            w_issue = w_adv;
            if (w_adv && w_sym_end) begin
               w_tready   = 1'b1;
               w_state_nx = s_axis_bit.tvalid ? S_SYM : S_IDLE;
            end
         end
         default: w_state_nx = S_IDLE;
      endcase
      if (reset) w_tready = 1'b0;
   end

   always_comb begin
      w_phase_nx = r_phase + w_inc;
`ifdef FSK_PHASE_RESET_EN
      // Cleared when the tlast sample is issued rather than when it leaves the
      // output register, so a back-to-back next packet still starts at phase 0.
      if (w_s0_last) w_phase_nx = '0;
`endif
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= S_IDLE;
         r_bit       <= 1'b0;
         r_bit_last  <= 1'b0;
         r_cnt       <= '0;
         r_phase     <= '0;
         r_s1_valid  <= 1'b0;
         r_s1_last   <= 1'b0;
         r_lut_i     <= '0;
         r_lut_q     <= '0;
         r_out_valid <= 1'b0;
         r_out_last  <= 1'b0;
         r_out_i     <= '0;
         r_out_q     <= '0;
      end else begin
         r_state <= w_state_nx;
         if (w_accept) begin
            r_bit      <= s_axis_bit.tdata[0];
            r_bit_last <= s_axis_bit.tlast;
            r_cnt      <= '0;
         end else if (w_issue) begin
            r_cnt <= r_cnt + CNT_W'(1);
         end
         if (w_issue) r_phase <= w_phase_nx;
         // ROM stage and output stage advance together; adv = 0 freezes both.
         if (w_adv) begin
            r_s1_valid  <= w_issue;
            r_s1_last   <= w_issue && w_s0_last;
            r_lut_i     <= w_rom[w_idx_i];
            r_lut_q     <= w_rom[w_idx_q];
            r_out_valid <= r_s1_valid;
            r_out_last  <= r_s1_last;
            r_out_i     <= r_lut_i;
            r_out_q     <= r_lut_q;
         end
      end
   end

   assign s_axis_bit.tready = w_tready;
   assign m_axis_i.tdata    = r_out_i;
   assign m_axis_i.tkeep    = '1;
   assign m_axis_i.tvalid   = r_out_valid;
   assign m_axis_i.tlast    = r_out_last;
   assign m_axis_q.tdata    = r_out_q;
   assign m_axis_q.tkeep    = '1;
   assign m_axis_q.tvalid   = r_out_valid;
   assign m_axis_q.tlast    = r_out_last;
endmodule
